aes_axil_frontend: RTL and testbench
====================================

AES_AXIL_FRONTEND -- requirements
Module: aes_axil_frontend

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 63, maximum cycles allowed from core_start to core_done.
REQ-004 Ports SHALL be, clock and reset first:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- s_axi_awaddr  in  6  write address.
- s_axi_awvalid/awready  in/out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid/wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid/bready  out/in  1  B handshake.
- s_axi_araddr  in  6  read address.
- s_axi_arvalid/arready  in/out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid/rready  out/in  1  R handshake.
- core_key  out  128  key to AES core; word0 = bits[31:0].
- core_pt  out  128  plaintext to AES core; word0 = bits[31:0].
- core_start  out  1  one-cycle start pulse.
- core_ct  in  128  ciphertext from AES core.
- core_done  in  1  one-cycle completion pulse.
- irq  out  1  level interrupt.
REQ-005 Clock SHALL be one domain; reset SHALL be synchronous, active-high.

Function
REQ-006 Register map (word offsets): 0x00 CTRL (bit0 START write-1 self-clearing, bit1 IRQ_EN); 0x04 STATUS (bit0 BUSY RO, bit1 DONE W1C, bit2 TIMEOUT W1C); 0x10-0x1C KEY0-3 RW; 0x20-0x2C PT0-3 RW; 0x30-0x3C CT0-3 RO.
REQ-007 Writes SHALL be accepted only when awvalid and wvalid are both high and bvalid is low; awready and wready SHALL pulse high together for exactly one cycle.
REQ-008 bvalid SHALL assert the cycle after the AW/W accept and hold until bready is sampled high.
REQ-009 wstrb SHALL gate each byte lane of KEY/PT/CTRL writes independently.
REQ-010 Writes to KEY/PT while BUSY, writes to CT, and writes to unmapped offsets SHALL not modify state and SHALL return bresp 2'b10 (SLVERR); all others return 2'b00.
REQ-011 arready SHALL pulse one cycle when arvalid is high and rvalid is low; rvalid SHALL assert the next cycle with rdata registered and hold until rready.
REQ-012 Unmapped reads SHALL return rdata 0, rresp 2'b10; mapped reads return rresp 2'b00.
REQ-013 FSM states IDLE, RUN. IDLE->RUN on START=1 write: core_start pulses one cycle, BUSY=1, DONE and TIMEOUT cleared, timeout counter cleared.
REQ-014 START written while RUN SHALL be ignored (bresp OKAY, no extra core_start).
REQ-015 RUN->IDLE on core_done: core_ct captured into CT0-3 the same edge, DONE=1, BUSY=0.
REQ-016 RUN->IDLE when counter reaches TIMEOUT_CYCLES without core_done: TIMEOUT=1, BUSY=0, CT unchanged.
REQ-017 core_done in IDLE SHALL be ignored.
REQ-018 Same-cycle W1C of DONE and its set by core_done SHALL leave DONE=1 (set wins).
REQ-019 irq SHALL equal IRQ_EN AND (DONE OR TIMEOUT), registered.
REQ-020 core_key/core_pt SHALL reflect the KEY/PT registers continuously and SHALL be stable throughout RUN.

Reset
REQ-021 On reset: all ready/valid outputs 0, bresp/rresp 0, rdata 0, core_start 0, irq 0, all registers 0, FSM IDLE, counter 0.
REQ-022 Reset during RUN SHALL abort to IDLE with no CT capture; pending B/R responses SHALL be dropped.

Verification
REQ-023 Write KEY=000102..0f, PT=00112233..ff, START -> one core_start pulse; model done after 41 cycles with CT=69c4e0d8..c55a -> CT0-3 read back exactly, DONE=1, BUSY=0.
REQ-024 Core never asserts done -> after 63 cycles TIMEOUT=1, BUSY=0, irq=1 when IRQ_EN=1.
REQ-025 Write PT0 during RUN -> bresp 2'b10, PT0 unchanged; write START during RUN -> no second core_start.
REQ-026 Hold bready/rready low 10 cycles -> bvalid/rvalid and data held stable, no new accepts.
REQ-027 W1C DONE in the same cycle as core_done -> DONE reads 1.
REQ-028 Assert reset at cycle 20 of RUN -> all outputs 0, BUSY=0, CT0-3 read 0.

Source files
------------

// File: rtl/aes_axil_frontend.sv
// AXI4-Lite register front end for a single-block AES core. It stages the key and
// plaintext, sequences start/done/timeout, captures the ciphertext and raises the interrupt.
module aes_axil_frontend #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES     = 63
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [127:0]                    core_key,
    output logic [127:0]                    core_pt,
    output logic                            core_start,
    input  logic [127:0]                    core_ct,
    input  logic                            core_done,
    output logic                            irq
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IDX_W-3:0] GRP_KEY = (IDX_W-2)'(1);
    localparam logic [IDX_W-3:0] GRP_PT  = (IDX_W-2)'(2);
    localparam logic [IDX_W-3:0] GRP_CT  = (IDX_W-2)'(3);

    logic [0:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [DW-1:0]    key_r [4];
    logic [DW-1:0]    pt_r  [4];
    logic [DW-1:0]    ct_r  [4];
    logic             irq_en;
    logic             done_r;
    logic             timeout_r;
    logic             busy;

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-3:0] w_grp;
    logic [IDX_W-3:0] r_grp;
    logic [1:0]       w_sel;
    logic [1:0]       r_sel;
    logic             wr_fire;
    logic             rd_fire;
    logic             w_ctrl;
    logic             w_status;
    logic             w_key;
    logic             w_pt;
    logic             w_ok;
    logic             start_req;
    logic [DW-1:0]    rd_word;
    logic             rd_ok;
    logic             unused_addr_bits;

    assign busy     = (state == ST_RUN);
    assign w_idx    = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign r_idx    = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_grp    = w_idx[IDX_W-1:2];
    assign r_grp    = r_idx[IDX_W-1:2];
    assign w_sel    = w_idx[1:0];
    assign r_sel    = r_idx[1:0];
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign core_key = {key_r[3], key_r[2], key_r[1], key_r[0]};
    assign core_pt  = {pt_r[3], pt_r[2], pt_r[1], pt_r[0]};

    // Handshakes: a ready pulse is raised only while the matching response slot
    // (bvalid/rvalid) is empty, so each channel holds at most one transaction. A
    // transfer happens on the edge where valid and ready are both high, and the
    // response valid then holds with stable payload until its ready is sampled high.
    assign wr_fire  = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
    assign rd_fire  = s_axi_arvalid && s_axi_arready;

    always_comb begin
        w_ctrl    = (w_idx == IDX_W'(0));
        w_status  = (w_idx == IDX_W'(1));
        w_key     = (w_grp == GRP_KEY);
        w_pt      = (w_grp == GRP_PT);
        // KEY/PT are frozen while the core runs so core_key/core_pt stay stable.
        w_ok      = w_ctrl || w_status || ((w_key || w_pt) && !busy);
        start_req = wr_fire && w_ctrl && s_axi_wstrb[0] && s_axi_wdata[0];
    end

    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        if (r_idx == IDX_W'(0)) begin
            rd_word[1] = irq_en;
        end else if (r_idx == IDX_W'(1)) begin
            rd_word[0] = busy;
            rd_word[1] = done_r;
            rd_word[2] = timeout_r;
        end else if (r_grp == GRP_KEY) begin
            rd_word = key_r[r_sel];
        end else if (r_grp == GRP_PT) begin
            rd_word = pt_r[r_sel];
        end else if (r_grp == GRP_CT) begin
            rd_word = ct_r[r_sel];
        end else begin
            rd_ok = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
            core_start    <= 1'b0;
            irq           <= 1'b0;
            irq_en        <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
            state         <= ST_IDLE;
            tmo_cnt       <= '0;
            for (int i = 0; i < 4; i++) begin
                key_r[i] <= '0;
                pt_r[i]  <= '0;
                ct_r[i]  <= '0;
            end
        end else begin
            core_start    <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;

            if (s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready) begin
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= w_ok ? 2'b00 : 2'b10;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (s_axi_arvalid && !s_axi_rvalid && !s_axi_arready) begin
                s_axi_arready <= 1'b1;
            end
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
                s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end

            if (wr_fire && w_ok) begin
                if (w_ctrl && s_axi_wstrb[0]) begin
                    irq_en <= s_axi_wdata[1];
                end
                if (w_status) begin
                    if (s_axi_wdata[1]) done_r    <= 1'b0;
                    if (s_axi_wdata[2]) timeout_r <= 1'b0;
                end
                for (int b = 0; b < NB; b++) begin
                    if (s_axi_wstrb[b]) begin
                        if (w_key) key_r[w_sel][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                        if (w_pt)  pt_r[w_sel][8*b +: 8]  <= s_axi_wdata[8*b +: 8];
                    end
                end
            end

            // Sequencing sits after the W1C logic so a completion wins over a same-cycle clear.
            if (state == ST_IDLE) begin
                if (start_req) begin
                    state      <= ST_RUN;
                    core_start <= 1'b1;
                    done_r     <= 1'b0;
                    timeout_r  <= 1'b0;
                    tmo_cnt    <= '0;
                end
            end else begin
                if (core_done) begin
                    for (int i = 0; i < 4; i++) ct_r[i] <= core_ct[32*i +: 32];
                    done_r <= 1'b1;
                    state  <= ST_IDLE;
                end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    timeout_r <= 1'b1;
                    state     <= ST_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end

            irq <= irq_en && (done_r || timeout_r);
        end
    end
endmodule

// File: tb/tb_aes_axil_frontend.sv
// Directed-plus-random bench for aes_axil_frontend, with an AXI-Lite bus driver and a
// behavioural register-map model that supplies every expected value.
module tb_aes_axil_frontend;
    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   s_axi_awaddr;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [5:0]   s_axi_araddr;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [127:0] core_key;
    logic [127:0] core_pt;
    logic         core_start;
    logic [127:0] core_ct;
    logic         core_done;
    logic         irq;

    aes_axil_frontend dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_key(core_key), .core_pt(core_pt), .core_start(core_start),
        .core_ct(core_ct), .core_done(core_done), .irq(irq)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (core_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register-map model
    logic [31:0] m_key [4];
    logic [31:0] m_pt  [4];
    logic [31:0] m_ct  [4];
    logic        m_irq_en, m_done, m_tmo, m_busy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = '0; m_pt[i] = '0; m_ct[i] = '0;
        end
        m_irq_en = 0; m_done = 0; m_tmo = 0; m_busy = 0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r);
        int w = int'(a) / 4;
        r = 2'b00;
        if (w == 0) begin
            if (s[0]) begin
                m_irq_en = d[1];
                if (d[0] && !m_busy) begin
                    m_busy = 1; m_done = 0; m_tmo = 0;
                end
            end
        end else if (w == 1) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_tmo = 0;
        end else if (w >= 4 && w <= 7) begin
            if (m_busy) r = 2'b10;
            else m_key[w-4] = merge(m_key[w-4], d, s);
        end else if (w >= 8 && w <= 11) begin
            if (m_busy) r = 2'b10;
            else m_pt[w-8] = merge(m_pt[w-8], d, s);
        end else begin
            r = 2'b10;
        end
    endtask

    task automatic model_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int w = int'(a) / 4;
        d = '0;
        r = 2'b00;
        if (w == 0) d = {30'd0, m_irq_en, 1'b0};
        else if (w == 1) d = {29'd0, m_tmo, m_done, m_busy};
        else if (w >= 4 && w <= 7) d = m_key[w-4];
        else if (w >= 8 && w <= 11) d = m_pt[w-8];
        else if (w >= 12) d = m_ct[w-12];
        else r = 2'b10;
    endtask

    // Bus driver tasks
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit fire_done, input logic [127:0] ct, input int hold,
                             input logic [1:0] exp_resp);
        int n = 0;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        while (!(s_axi_awready && s_axi_wready) && n < 20) begin
            @(posedge clock); #1; n++;
        end
        chk("aw_w_ready", {s_axi_awready, s_axi_wready}, 2'b11);
        if (fire_done) begin
            core_done = 1; core_ct = ct;
        end
        @(posedge clock); #1;
        core_done = 0; s_axi_awvalid = 0; s_axi_wvalid = 0;
        chk("aw_w_pulse", {s_axi_awready, s_axi_wready}, 2'b00);
        chk("bvalid_set", s_axi_bvalid, 1'b1);
        chk($sformatf("bresp_%0h", a), s_axi_bresp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            s_axi_awaddr = 6'h20; s_axi_wdata = $urandom; s_axi_wstrb = 4'hf;
            s_axi_awvalid = 1; s_axi_wvalid = 1;
            @(posedge clock); #1;
            chk("b_hold_valid", s_axi_bvalid, 1'b1);
            chk("b_hold_resp", s_axi_bresp, exp_resp);
            chk("b_hold_noaccept", {s_axi_awready, s_axi_wready}, 2'b00);
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_bready = 1;
        @(posedge clock); #1;
        s_axi_bready = 0;
        chk("bvalid_clr", s_axi_bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [5:0] a, input int hold, input logic [31:0] ed,
                            input logic [1:0] er);
        int n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1;
        while (!s_axi_arready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        chk("ar_ready", s_axi_arready, 1'b1);
        @(posedge clock); #1;
        s_axi_arvalid = 0;
        chk("ar_pulse", s_axi_arready, 1'b0);
        chk("rvalid_set", s_axi_rvalid, 1'b1);
        chk($sformatf("rdata_%0h", a), s_axi_rdata, ed);
        chk($sformatf("rresp_%0h", a), s_axi_rresp, er);
        for (int i = 0; i < hold; i++) begin
            s_axi_araddr = 6'h04; s_axi_arvalid = 1;
            @(posedge clock); #1;
            chk("r_hold_valid", s_axi_rvalid, 1'b1);
            chk("r_hold_data", s_axi_rdata, ed);
            chk("r_hold_resp", s_axi_rresp, er);
            chk("r_hold_noaccept", s_axi_arready, 1'b0);
        end
        s_axi_arvalid = 0;
        s_axi_rready = 1;
        @(posedge clock); #1;
        s_axi_rready = 0;
        chk("rvalid_clr", s_axi_rvalid, 1'b0);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        model_write(a, d, s, r);
        axi_write(a, d, s, 1'b0, '0, 0, r);
    endtask

    task automatic do_read(input logic [5:0] a);
        logic [31:0] ed;
        logic [1:0]  er;
        model_read(a, ed, er);
        axi_read(a, 0, ed, er);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic pulse_done(input int lat, input logic [127:0] ct);
        wait_until(start_cyc + lat);
        core_done = 1; core_ct = ct;
        @(posedge clock); #1;
        core_done = 0;
        m_busy = 0; m_done = 1;
        for (int i = 0; i < 4; i++) m_ct[i] = ct[32*i +: 32];
    endtask

    task automatic check_outputs_zero();
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_bresp", s_axi_bresp, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_rresp", s_axi_rresp, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_irq", irq, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_pt", core_pt, 0);
    endtask

    initial begin
        logic [127:0] key_vec, pt_vec, ct_vec, rnd_ct;
        logic [1:0]   r;
        logic [5:0]   a;
        int           n0, n;

        key_vec = 128'h000102030405060708090a0b0c0d0e0f;
        pt_vec  = 128'h00112233445566778899aabbccddeeff;
        ct_vec  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        reset = 1;
        s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        core_ct = 0; core_done = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero();
        reset = 0;
        @(posedge clock); #1;

        do_read(6'h00);
        do_read(6'h04);

        // Random KEY/PT writes with random byte strobes, then full readback
        for (int i = 0; i < 16; i++) begin
            a = 6'(4 * $urandom_range(4, 11));
            do_write(a, $urandom, 4'($urandom_range(0, 15)));
        end
        for (int i = 4; i < 12; i++) do_read(6'(4 * i));
        chk("core_key_rand", core_key, {m_key[3], m_key[2], m_key[1], m_key[0]});
        chk("core_pt_rand", core_pt, {m_pt[3], m_pt[2], m_pt[1], m_pt[0]});

        // CTRL byte strobe gating
        do_write(6'h00, 32'h2, 4'h0);
        do_read(6'h00);
        do_write(6'h00, 32'h2, 4'h1);
        do_read(6'h00);

        // Known-answer run with IRQ enabled
        for (int i = 0; i < 4; i++) begin
            do_write(6'(6'h10 + 4 * i), key_vec[32*i +: 32], 4'hf);
            do_write(6'(6'h20 + 4 * i), pt_vec[32*i +: 32], 4'hf);
        end
        n0 = start_cnt;
        do_write(6'h00, 32'h3, 4'h1);
        chk("start_once", start_cnt, n0 + 1);
        chk("core_key_kat", core_key, key_vec);
        chk("core_pt_kat", core_pt, pt_vec);
        do_read(6'h04);
        do_write(6'h20, $urandom, 4'hf);
        do_read(6'h20);
        do_write(6'h00, 32'h3, 4'h1);
        chk("no_restart", start_cnt, n0 + 1);
        chk("core_pt_stable", core_pt, pt_vec);
        pulse_done(41, ct_vec);
        for (int i = 12; i < 16; i++) do_read(6'(4 * i));
        do_read(6'h04);
        chk("irq_done", irq, m_irq_en & (m_done | m_tmo));

        do_write(6'h04, 32'h2, 4'hf);
        do_read(6'h04);
        chk("irq_cleared", irq, m_irq_en & (m_done | m_tmo));

        // Random run with IRQ disabled and random latency
        for (int i = 0; i < 4; i++) do_write(6'(6'h10 + 4 * i), $urandom, 4'hf);
        rnd_ct = {$urandom, $urandom, $urandom, $urandom};
        do_write(6'h00, 32'h1, 4'h1);
        pulse_done($urandom_range(5, 50), rnd_ct);
        for (int i = 12; i < 16; i++) do_read(6'(4 * i));
        do_read(6'h04);
        chk("irq_disabled", irq, m_irq_en & (m_done | m_tmo));

        // Timeout run with IRQ enabled
        n0 = start_cnt;
        do_write(6'h00, 32'h3, 4'h1);
        chk("start_tmo", start_cnt, n0 + 1);
        wait_until(start_cyc + 60);
        do_read(6'h04);
        wait_until(start_cyc + 64);
        m_busy = 0; m_tmo = 1;
        do_read(6'h04);
        do_read(6'h30);
        chk("irq_timeout", irq, m_irq_en & (m_done | m_tmo));
        core_done = 1; core_ct = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clock); #1;
        core_done = 0;
        do_read(6'h30);
        do_read(6'h04);
        do_write(6'h04, 32'h4, 4'hf);
        do_read(6'h04);

        // Backpressure on B and R
        model_write(6'h10, 32'hA5A55A5A, 4'hf, r);
        axi_write(6'h10, 32'hA5A55A5A, 4'hf, 1'b0, '0, 10, r);
        begin
            logic [31:0] ed;
            logic [1:0]  er;
            model_read(6'h10, ed, er);
            axi_read(6'h10, 10, ed, er);
        end
        do_read(6'h20);

        // DONE clear in the same cycle as completion
        do_write(6'h00, 32'h1, 4'h1);
        rnd_ct = {$urandom, $urandom, $urandom, $urandom};
        model_write(6'h04, 32'h2, 4'hf, r);
        axi_write(6'h04, 32'h2, 4'hf, 1'b1, rnd_ct, 0, r);
        m_busy = 0; m_done = 1;
        for (int i = 0; i < 4; i++) m_ct[i] = rnd_ct[32*i +: 32];
        do_read(6'h04);
        do_read(6'h3C);

        // Unmapped and read-only offsets
        do_read(6'h08);
        do_read(6'h0C);
        do_write(6'h08, $urandom, 4'hf);
        do_write(6'h0C, $urandom, 4'hf);
        do_write(6'h34, $urandom, 4'hf);
        do_read(6'h34);
        for (int i = 0; i < 8; i++) do_read(6'(4 * $urandom_range(0, 15)));

        // Reset in the middle of a run with a write response pending
        do_write(6'h00, 32'h1, 4'h1);
        wait_until(start_cyc + 18);
        s_axi_awaddr = 6'h10; s_axi_wdata = $urandom; s_axi_wstrb = 4'hf;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0;
        while (!s_axi_awready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        chk("b_pending", s_axi_bvalid, 1'b1);
        reset = 1;
        @(posedge clock); #1;
        model_reset();
        check_outputs_zero();
        reset = 0;
        @(posedge clock); #1;
        do_read(6'h04);
        for (int i = 12; i < 16; i++) do_read(6'(4 * i));
        do_read(6'h10);
        do_read(6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
